// File: rtl/vga_motion_pkg.sv
// Shared constants, types and the per-axis bounce rule for the VGA motion scheduler.
//   COORD_W / PERIOD_W : coordinate and step-period widths
//   X_MAX, Y_MIN, Y_MAX: legal top-left bounds of a 40x40 square (x lower bound is 0)
//   RST_X, RST_Y       : position loaded for every object at reset
//   state_e            : scheduler state encoding
//   motion_t           : one object's position and direction (1 = increasing)
package vga_motion_pkg;

    localparam int unsigned COORD_W  = 10;
    localparam int unsigned PERIOD_W = 7;
    localparam int unsigned OBJ_SIZE = 40;
    localparam int unsigned X_MAX    = 600;
    localparam int unsigned Y_MIN    = 10;
    localparam int unsigned Y_MAX    = 440;

    typedef logic [COORD_W-1:0] coord_t;

    localparam coord_t RST_X = COORD_W'(320);
    localparam coord_t RST_Y = COORD_W'(220);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        UPDATE = 2'd1,
        COMMIT = 2'd2
    } state_e;

    typedef struct packed {
        coord_t x;
        coord_t y;
        logic   dx;
        logic   dy;
    } motion_t;

    // One axis step: returns {next_dir, next_pos}; hitting a bound reverses and steps back inside.
    function automatic logic [COORD_W:0] step_axis(input coord_t pos, input logic dir,
                                                   input coord_t lo, input coord_t hi);
        logic [COORD_W:0] res;
        if (dir) begin
            if (pos >= hi) res = {1'b0, pos - COORD_W'(1)};
            else           res = {1'b1, pos + COORD_W'(1)};
        end else begin
            if (pos <= lo) res = {1'b1, pos + COORD_W'(1)};
            else           res = {1'b0, pos - COORD_W'(1)};
        end
        return res;
    endfunction

endpackage

// File: rtl/vga_motion_scheduler_if.sv
// Control/status bundle between the VGA timing/UI logic and the motion scheduler.
//   frame_start, faster, slower, sel, [pause] : driven by master
//   obj_x, obj_y, busy, overrun                : driven by slave (the scheduler)
// pause exists only when MOTION_PAUSE_EN is defined.
interface vga_motion_scheduler_if #(
    parameter int unsigned NUM_OBJ = 2
);
    logic                   frame_start;
    logic                   faster;
    logic                   slower;
    logic [1:0]             sel;
`ifdef MOTION_PAUSE_EN
    logic                   pause;
`endif
    logic [10*NUM_OBJ-1:0]  obj_x;
    logic [10*NUM_OBJ-1:0]  obj_y;
    logic                   busy;
    logic                   overrun;

    modport master (
`ifdef MOTION_PAUSE_EN
        output pause,
`endif
        output frame_start, faster, slower, sel,
        input  obj_x, obj_y, busy, overrun
    );

    modport slave (
`ifdef MOTION_PAUSE_EN
        input  pause,
`endif
        input  frame_start, faster, slower, sel,
        output obj_x, obj_y, busy, overrun
    );
endinterface

// File: rtl/motion_step_unit.sv
// Combinational bounce step for one object, shared by all objects.
//   cur   : current position/direction
//   nxt_c : position/direction after one step (both axes may flip at a corner)
module motion_step_unit
    import vga_motion_pkg::*;
#(
    parameter int unsigned X_MAX = vga_motion_pkg::X_MAX,
    parameter int unsigned Y_MIN = vga_motion_pkg::Y_MIN,
    parameter int unsigned Y_MAX = vga_motion_pkg::Y_MAX
) (
    input  motion_t cur,
    output motion_t nxt_c
);

    assign {nxt_c.dx, nxt_c.x} = step_axis(cur.x, cur.dx, '0, COORD_W'(X_MAX));
    assign {nxt_c.dy, nxt_c.y} = step_axis(cur.y, cur.dy, COORD_W'(Y_MIN), COORD_W'(Y_MAX));

endmodule

// File: rtl/vga_motion_scheduler.sv
// Schedules per-frame position updates for up to 4 bouncing squares and commits
// them together so rendering never sees a mixed-frame set of positions.
//   clk, rst (synchronous, active-high)
//   bus.frame_start : vblank-start pulse; bus.faster/slower/sel : per-object speed control
//   bus.obj_x/obj_y : committed positions, 10 bits per object
//   bus.busy        : scheduler not idle; bus.overrun : frame_start dropped while busy
// Optional feature macro: MOTION_PAUSE_EN (adds bus.pause, which masks frame_start).
module vga_motion_scheduler
    import vga_motion_pkg::*;
#(
    parameter int unsigned NUM_OBJ    = 2,
    parameter int unsigned PERIOD_MIN = 1,
    parameter int unsigned PERIOD_MAX = 64,
    parameter int unsigned PERIOD_RST = 8,
    parameter int unsigned X_MAX      = vga_motion_pkg::X_MAX,
    parameter int unsigned Y_MIN      = vga_motion_pkg::Y_MIN,
    parameter int unsigned Y_MAX      = vga_motion_pkg::Y_MAX
) (
    input  logic                  clk,
    input  logic                  rst,
    vga_motion_scheduler_if.slave bus
);

    localparam int unsigned POS_W = NUM_OBJ * COORD_W;

    state_e                state_q, state_d;
    motion_t               sh_q     [NUM_OBJ];
    motion_t               sh_d     [NUM_OBJ];
    logic [PERIOD_W-1:0]   period_q [NUM_OBJ];
    logic [PERIOD_W-1:0]   period_d [NUM_OBJ];
    logic [PERIOD_W-1:0]   cnt_q    [NUM_OBJ];
    logic [PERIOD_W-1:0]   cnt_d    [NUM_OBJ];
    logic [NUM_OBJ-1:0]    pend_q, pend_d;
    logic [POS_W-1:0]      obj_x_q, obj_x_d;
    logic [POS_W-1:0]      obj_y_q, obj_y_d;
    logic                  busy_q, busy_d;
    logic                  overrun_q, overrun_d;

    logic                  pause_c;
    logic                  fs_c;
    logic [NUM_OBJ-1:0]    grant_c;
    motion_t               step_in_c;
    motion_t               step_out_c;

`ifdef MOTION_PAUSE_EN
    assign pause_c = bus.pause;
`else
    assign pause_c = 1'b0;
`endif
    assign fs_c = bus.frame_start & ~pause_c;

    // Lowest-index pending object owns the shared step unit this cycle.
    always_comb begin
        grant_c   = pend_q & (~pend_q + NUM_OBJ'(1));
        step_in_c = sh_q[0];
        for (int i = 0; i < NUM_OBJ; i++) begin
            if (grant_c[i]) step_in_c = sh_q[i];
        end
    end

    motion_step_unit #(
        .X_MAX (X_MAX),
        .Y_MIN (Y_MIN),
        .Y_MAX (Y_MAX)
    ) u_step (
        .cur   (step_in_c),
        .nxt_c (step_out_c)
    );

    // Next-state, speed control, scheduling and commit.
    always_comb begin
        state_d   = state_q;
        sh_d      = sh_q;
        period_d  = period_q;
        cnt_d     = cnt_q;
        pend_d    = pend_q;
        obj_x_d   = obj_x_q;
        obj_y_d   = obj_y_q;
        overrun_d = 1'b0;

        // Speed changes are live in every state; the frame compare below sees the old period.
        for (int i = 0; i < NUM_OBJ; i++) begin
            if (2'(i) == bus.sel && (bus.faster ^ bus.slower)) begin
                if (bus.faster && period_q[i] > PERIOD_W'(PERIOD_MIN))
                    period_d[i] = period_q[i] - PERIOD_W'(1);
                if (bus.slower && period_q[i] < PERIOD_W'(PERIOD_MAX))
                    period_d[i] = period_q[i] + PERIOD_W'(1);
            end
        end

        case (state_q)
            IDLE: begin
                if (fs_c) begin
                    for (int i = 0; i < NUM_OBJ; i++) begin
                        // >= so a period lowered below the running count fires at once
                        if (cnt_q[i] >= period_q[i] - PERIOD_W'(1)) begin
                            pend_d[i] = 1'b1;
                            cnt_d[i]  = '0;
                        end else begin
                            cnt_d[i]  = cnt_q[i] + PERIOD_W'(1);
                        end
                    end
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                for (int i = 0; i < NUM_OBJ; i++) begin
                    if (grant_c[i]) sh_d[i] = step_out_c;
                end
                pend_d = pend_q & ~grant_c;
                if (pend_d == '0) state_d = COMMIT;
            end
            COMMIT: begin
                for (int i = 0; i < NUM_OBJ; i++) begin
                    obj_x_d[i*COORD_W +: COORD_W] = sh_q[i].x;
                    obj_y_d[i*COORD_W +: COORD_W] = sh_q[i].y;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (fs_c && state_q != IDLE) overrun_d = 1'b1;
        busy_d = (state_d != IDLE);
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pend_q    <= '0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
            for (int i = 0; i < NUM_OBJ; i++) begin
                sh_q[i]     <= '{x: RST_X, y: RST_Y, dx: 1'(i), dy: 1'(i >> 1)};
                period_q[i] <= PERIOD_W'(PERIOD_RST);
                cnt_q[i]    <= '0;
                obj_x_q[i*COORD_W +: COORD_W] <= RST_X;
                obj_y_q[i*COORD_W +: COORD_W] <= RST_Y;
            end
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            busy_q    <= busy_d;
            overrun_q <= overrun_d;
            sh_q      <= sh_d;
            period_q  <= period_d;
            cnt_q     <= cnt_d;
            obj_x_q   <= obj_x_d;
            obj_y_q   <= obj_y_d;
        end
    end

    assign bus.obj_x   = obj_x_q;
    assign bus.obj_y   = obj_y_q;
    assign bus.busy    = busy_q;
    assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_vga_motion_scheduler.sv
// Randomised + directed bench for vga_motion_scheduler with a frame-level reference model
// and a commit scoreboard.
module tb_vga_motion_scheduler;

    localparam int N = 3;
    localparam int W = 10 * N;

    typedef struct packed {
        logic [W-1:0] x;
        logic [W-1:0] y;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vga_motion_scheduler_if #(.NUM_OBJ(N)) bus ();

    vga_motion_scheduler #(.NUM_OBJ(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: object state in plain integers, frame-level behaviour.
    int m_x [N], m_y [N], m_dx [N], m_dy [N], m_per [N], m_cnt [N];
    int m_rem;          // cycles the scheduler will still report busy
    logic pz_drv = 1'b0;
    exp_t sb [$];

    function automatic exp_t reset_pos();
        exp_t e;
        for (int i = 0; i < N; i++) begin
            e.x[10*i +: 10] = 10'd320;
            e.y[10*i +: 10] = 10'd220;
        end
        return e;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < N; i++) begin
            m_x[i] = 320; m_y[i] = 220;
            m_dx[i] = i % 2; m_dy[i] = (i / 2) % 2;
            m_per[i] = 8; m_cnt[i] = 0;
        end
        m_rem = 0;
    endtask

    // Bounce on [lo, hi]: moving into a wall reverses and steps one pixel back.
    task automatic bounce(inout int p, inout int d, input int lo, input int hi);
        if (d == 1) begin
            if (p >= hi) begin d = 0; p = p - 1; end else p = p + 1;
        end else begin
            if (p <= lo) begin d = 1; p = p + 1; end else p = p - 1;
        end
    endtask

    task automatic check1(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    // One clock cycle: drive at negedge, advance the model, check busy/overrun after the edge.
    task automatic tick(input logic fs, input logic fa, input logic sl,
                        input logic [1:0] s, input logic rs);
        int  k;
        bit  busy_before, exp_ovr;
        exp_t e;
        @(negedge clk);
        bus.frame_start = fs;
        bus.faster      = fa;
        bus.slower      = sl;
        bus.sel         = s;
`ifdef MOTION_PAUSE_EN
        bus.pause       = pz_drv;
`endif
        rst             = rs;
        exp_ovr         = 0;
        if (rs) begin
            m_reset();
            sb.delete();
        end else begin
            busy_before = (m_rem > 0);
            if (m_rem > 0) m_rem--;
            if (fs && !pz_drv) begin
                if (busy_before) exp_ovr = 1;
                else begin
                    k = 0;
                    for (int i = 0; i < N; i++) begin
                        if (m_cnt[i] >= m_per[i] - 1) begin
                            m_cnt[i] = 0;
                            bounce(m_x[i], m_dx[i], 0, 600);
                            bounce(m_y[i], m_dy[i], 10, 440);
                            k++;
                        end else m_cnt[i]++;
                    end
                    m_rem = ((k > 1) ? k : 1) + 1;
                    for (int i = 0; i < N; i++) begin
                        e.x[10*i +: 10] = 10'(m_x[i]);
                        e.y[10*i +: 10] = 10'(m_y[i]);
                    end
                    sb.push_back(e);
                end
            end
            if (fa != sl && int'(s) < N) begin
                if (fa) m_per[s] = (m_per[s] > 1)  ? m_per[s] - 1 : 1;
                else    m_per[s] = (m_per[s] < 64) ? m_per[s] + 1 : 64;
            end
        end
        @(posedge clk);
        #1;
        check1("busy", int'(bus.busy), int'(m_rem > 0));
        check1("overrun", int'(bus.overrun), int'(exp_ovr));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, 0, 2'd0, 0);
    endtask

    task automatic all_fastest();
        for (int o = 0; o < N; o++)
            for (int j = 0; j < 10; j++) tick(0, 1, 0, 2'(o), 0);
    endtask

    // Monitor: committed positions must hold until busy drops, then match the next scoreboard entry.
    initial begin
        exp_t cur;
        logic prev_busy;
        cur = reset_pos();
        prev_busy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                cur = reset_pos();
                prev_busy = 1'b0;
            end else begin
                if (prev_busy && !bus.busy) begin
                    if (sb.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL commit_unexpected actual=busy_fall required=none at %0t", $time);
                    end else cur = sb.pop_front();
                end
                prev_busy = bus.busy;
            end
            checks++;
            if (bus.obj_x !== cur.x || bus.obj_y !== cur.y) begin
                errors++;
                $display("FAIL positions actual x=%h y=%h required x=%h y=%h at %0t",
                         bus.obj_x, bus.obj_y, cur.x, cur.y, $time);
            end
        end
    end

    initial begin
        bus.frame_start = 0; bus.faster = 0; bus.slower = 0; bus.sel = 0;
`ifdef MOTION_PAUSE_EN
        bus.pause = 0;
`endif
        m_reset();

        // Reset and idle
        tick(0, 0, 0, 2'd0, 1);
        tick(0, 0, 0, 2'd0, 1);
        idle(10);

        // Saturating speed control, simultaneous pulses, out-of-range sel
        all_fastest();
        tick(0, 1, 1, 2'd0, 0);
        tick(0, 1, 0, 2'd3, 0);
        tick(0, 0, 1, 2'd3, 0);

        // All objects fire on one frame, then a frame_start during UPDATE
        tick(1, 0, 0, 2'd0, 0);
        idle(6);
        tick(1, 0, 0, 2'd0, 0);
        tick(1, 0, 0, 2'd0, 0);
        idle(6);

        // Reset mid-UPDATE, then normal stepping
        tick(1, 0, 0, 2'd0, 0);
        tick(0, 0, 0, 2'd0, 0);
        tick(0, 0, 0, 2'd0, 1);
        idle(3);
        all_fastest();
        tick(1, 0, 0, 2'd0, 0);
        idle(6);

        // Long run at period 1: walls at x=0, x=600, y=10 are all reached
        for (int f = 0; f < 700; f++) begin
            tick(1, 0, 0, 2'd0, 0);
            idle(5);
        end

        // Slowest period saturates at 64
        for (int j = 0; j < 70; j++) tick(0, 0, 1, 2'd2, 0);
        for (int f = 0; f < 130; f++) begin
            tick(1, 0, 0, 2'd0, 0);
            idle(4);
        end

        // Random traffic
        for (int c = 0; c < 4000; c++) begin
`ifdef MOTION_PAUSE_EN
            pz_drv = ($urandom_range(0, 7) == 0);
`endif
            tick(($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 7) == 0), 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 499) == 0));
        end
        pz_drv = 1'b0;
        idle(8);
        check1("scoreboard_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
